// File: rtl/register_renamer.sv
// Rename stage: maps architectural to physical registers through a speculative map table,
// a circular free list and per-PRN ready bits. Optional stall counters: RENAME_STALL_STATS_EN.
module register_renamer #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int PRN_COUNT    = 64,
    parameter int ARN_BITS     = 5,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INST_ID_BITS-1:0] in_inst_id,
    input  logic [31:0]             in_raw_instr,
    input  logic [63:0]             in_pc,
    input  logic                    src_valid [MAX_OPERANDS],
    input  logic [ARN_BITS-1:0]     src_arn [MAX_OPERANDS],
    input  logic                    dst_valid [MAX_OPERANDS],
    input  logic [ARN_BITS-1:0]     dst_arn [MAX_OPERANDS],
    output logic                    inst_valid,
    input  logic                    queue_ready,
    output logic [INST_ID_BITS-1:0] inst_id,
    output logic [31:0]             raw_instr,
    output logic [63:0]             instr_pc,
    output logic                    prn_input_valid [MAX_OPERANDS],
    output logic                    prn_input_ready [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     prn_input [MAX_OPERANDS],
    output logic                    prn_output_valid [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     prn_output [MAX_OPERANDS],
    input  logic                    set_prn_ready [FU_COUNT][MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     set_prn [FU_COUNT][MAX_OPERANDS],
    input  logic                    free_valid [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     free_prn [MAX_OPERANDS],
    output logic [PRN_BITS:0]       free_count
`ifdef RENAME_STALL_STATS_EN
    ,
    output logic [31:0]             stall_free_cycles,
    output logic [31:0]             stall_queue_cycles
`endif
);

    localparam int ARN_COUNT = 1 << ARN_BITS;
    localparam int INIT_FREE = PRN_COUNT - ARN_COUNT;
    localparam int CNT_W     = $clog2(MAX_OPERANDS + 1);
    localparam int CW        = PRN_BITS + 2;
    localparam logic [ARN_BITS-1:0] XZR_ARN = '1;

    logic [PRN_BITS-1:0] map_reg [ARN_COUNT];
    logic [PRN_COUNT-1:0] ready_reg;
    logic [PRN_BITS-1:0] fl_mem [PRN_COUNT];
    logic [PRN_BITS-1:0] fl_head_reg;
    logic [PRN_BITS-1:0] fl_tail_reg;
    logic [PRN_BITS:0]   free_count_reg;

    logic [PRN_COUNT-1:0] wake_vec;
    logic [PRN_COUNT-1:0] alloc_mask;
    logic                 dst_alloc [MAX_OPERANDS];
    logic [PRN_BITS-1:0]  alloc_prn [MAX_OPERANDS];
    logic [CNT_W-1:0]     pop_cnt;
    logic                 push_en [MAX_OPERANDS];
    logic [CNT_W-1:0]     push_off [MAX_OPERANDS];
    logic [CNT_W-1:0]     push_cnt;
    logic [PRN_BITS-1:0]  src_prn [MAX_OPERANDS];
    logic                 src_rdy [MAX_OPERANDS];
    logic                 free_ok;
    logic                 accept;
    logic [CW-1:0]        count_next;

    always_comb begin
        wake_vec = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (set_prn_ready[f][i]) wake_vec[set_prn[f][i]] = 1'b1;
            end
        end
    end

    // Destinations pop consecutive free-list entries in slot order; XZR allocates nothing.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            dst_alloc[i] = dst_valid[i] && (dst_arn[i] != XZR_ARN);
            alloc_prn[i] = '0;
            if (dst_alloc[i]) begin
                alloc_prn[i] = fl_mem[fl_head_reg + PRN_BITS'(pop_cnt)];
                pop_cnt      = pop_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            push_en[i]  = free_valid[i] && (free_prn[i] != '0);
            push_off[i] = push_cnt;
            if (push_en[i]) push_cnt = push_cnt + CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_OPERANDS; gi++) begin : g_src
            assign src_prn[gi] = (src_arn[gi] == XZR_ARN) ? '0 : map_reg[src_arn[gi]];
            assign src_rdy[gi] = ready_reg[src_prn[gi]] | wake_vec[src_prn[gi]];
        end
    endgenerate

    assign free_ok    = free_count_reg >= (PRN_BITS + 1)'(pop_cnt);
    assign in_ready   = (!inst_valid || queue_ready) && free_ok;
    assign accept     = in_valid && in_ready;
    assign free_count = free_count_reg;
    assign count_next = CW'(free_count_reg) + CW'(push_cnt) - (accept ? CW'(pop_cnt) : CW'(0));

    always_comb begin
        alloc_mask = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            if (accept && dst_alloc[i]) alloc_mask[alloc_prn[i]] = 1'b1;
        end
    end

    // Map table, ready bits and free list; allocation clears override same-cycle wakeups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < ARN_COUNT; a++) begin
                map_reg[a] <= (a == ARN_COUNT - 1) ? '0 : PRN_BITS'(a + 1);
            end
            for (int k = 0; k < PRN_COUNT; k++) begin
                fl_mem[k] <= (k < INIT_FREE) ? PRN_BITS'(ARN_COUNT + k) : '0;
            end
            ready_reg      <= '1;
            fl_head_reg    <= '0;
            fl_tail_reg    <= PRN_BITS'(INIT_FREE);
            free_count_reg <= (PRN_BITS + 1)'(INIT_FREE);
        end else begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (accept && dst_alloc[i]) map_reg[dst_arn[i]] <= alloc_prn[i];
                if (push_en[i]) fl_mem[fl_tail_reg + PRN_BITS'(push_off[i])] <= free_prn[i];
            end
            ready_reg      <= ((ready_reg | wake_vec) & ~alloc_mask) | PRN_COUNT'(1);
            fl_head_reg    <= fl_head_reg + (accept ? PRN_BITS'(pop_cnt) : '0);
            fl_tail_reg    <= fl_tail_reg + PRN_BITS'(push_cnt);
            free_count_reg <= count_next[PRN_BITS:0];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) assert (count_next <= CW'(PRN_COUNT));
    end
`endif

    // Output stage: load on accept, drop when drained, otherwise hold and absorb wakeups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst_id    <= '0;
            raw_instr  <= '0;
            instr_pc   <= '0;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                prn_input_valid[i]  <= 1'b0;
                prn_input_ready[i]  <= 1'b0;
                prn_input[i]        <= '0;
                prn_output_valid[i] <= 1'b0;
                prn_output[i]       <= '0;
            end
        end else if (accept) begin
            inst_valid <= 1'b1;
            inst_id    <= in_inst_id;
            raw_instr  <= in_raw_instr;
            instr_pc   <= in_pc;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                prn_input_valid[i]  <= src_valid[i];
                prn_input_ready[i]  <= src_valid[i] && src_rdy[i];
                prn_input[i]        <= src_valid[i] ? src_prn[i] : '0;
                prn_output_valid[i] <= dst_valid[i];
                prn_output[i]       <= alloc_prn[i];
            end
        end else if (queue_ready) begin
            inst_valid <= 1'b0;
        end else if (inst_valid) begin
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                if (prn_input_valid[i] && wake_vec[prn_input[i]]) prn_input_ready[i] <= 1'b1;
            end
        end
    end

`ifdef RENAME_STALL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_free_cycles  <= '0;
            stall_queue_cycles <= '0;
        end else begin
            if (in_valid && !free_ok && (stall_free_cycles != '1))
                stall_free_cycles <= stall_free_cycles + 32'd1;
            if (inst_valid && !queue_ready && (stall_queue_cycles != '1))
                stall_queue_cycles <= stall_queue_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_register_renamer.sv
// Scoreboard bench for register_renamer: a behavioural map/free-list model predicts each renamed
// instruction when it is accepted; predictions are compared when the output stage updates.
module tb_register_renamer;

    typedef struct packed {
        logic [5:0]       id;
        logic [31:0]      raw;
        logic [63:0]      pc;
        logic [2:0]       piv;
        logic [2:0]       pir;
        logic [2:0][5:0]  pi;
        logic [2:0]       pov;
        logic [2:0][5:0]  po;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid;
    logic in_ready;
    logic [5:0] in_inst_id;
    logic [31:0] in_raw_instr;
    logic [63:0] in_pc;
    logic src_valid [3];
    logic [4:0] src_arn [3];
    logic dst_valid [3];
    logic [4:0] dst_arn [3];
    logic inst_valid;
    logic queue_ready;
    logic [5:0] inst_id;
    logic [31:0] raw_instr;
    logic [63:0] instr_pc;
    logic prn_input_valid [3];
    logic prn_input_ready [3];
    logic [5:0] prn_input [3];
    logic prn_output_valid [3];
    logic [5:0] prn_output [3];
    logic set_prn_ready [4][3];
    logic [5:0] set_prn [4][3];
    logic free_valid [3];
    logic [5:0] free_prn [3];
    logic [6:0] free_count;
`ifdef RENAME_STALL_STATS_EN
    logic [31:0] stall_free_cycles;
    logic [31:0] stall_queue_cycles;
`endif

    register_renamer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_pc(in_pc),
        .src_valid(src_valid), .src_arn(src_arn), .dst_valid(dst_valid), .dst_arn(dst_arn),
        .inst_valid(inst_valid), .queue_ready(queue_ready), .inst_id(inst_id),
        .raw_instr(raw_instr), .instr_pc(instr_pc),
        .prn_input_valid(prn_input_valid), .prn_input_ready(prn_input_ready),
        .prn_input(prn_input), .prn_output_valid(prn_output_valid), .prn_output(prn_output),
        .set_prn_ready(set_prn_ready), .set_prn(set_prn),
        .free_valid(free_valid), .free_prn(free_prn), .free_count(free_count)
`ifdef RENAME_STALL_STATS_EN
        , .stall_free_cycles(stall_free_cycles), .stall_queue_cycles(stall_queue_cycles)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int   m_map [32];
    bit   m_ready [64];
    int   m_free [$];
    out_t m_out;
    bit   m_out_valid;
    out_t sb [$];
    int   pool [$];
    bit   last_acc;

    task automatic model_reset();
        for (int a = 0; a < 31; a++) m_map[a] = a + 1;
        m_map[31] = 0;
        for (int p = 0; p < 64; p++) m_ready[p] = 1'b1;
        m_free.delete();
        for (int p = 32; p < 64; p++) m_free.push_back(p);
        m_out = '0;
        m_out_valid = 1'b0;
        sb.delete();
        pool.delete();
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.id = inst_id; o.raw = raw_instr; o.pc = instr_pc;
        for (int i = 0; i < 3; i++) begin
            o.piv[i] = prn_input_valid[i];
            o.pir[i] = prn_input_ready[i];
            o.pi[i]  = prn_input[i];
            o.pov[i] = prn_output_valid[i];
            o.po[i]  = prn_output[i];
        end
        return o;
    endfunction

    task automatic idle();
        in_valid = 1'b0; in_inst_id = '0; in_raw_instr = '0; in_pc = '0;
        for (int i = 0; i < 3; i++) begin
            src_valid[i] = 1'b0; src_arn[i] = '0; dst_valid[i] = 1'b0; dst_arn[i] = '0;
            free_valid[i] = 1'b0; free_prn[i] = '0;
            for (int f = 0; f < 4; f++) begin
                set_prn_ready[f][i] = 1'b0; set_prn[f][i] = '0;
            end
        end
    endtask

    task automatic set_inst(input logic [5:0] id, input logic [2:0] sv, input logic [14:0] sa,
                            input logic [2:0] dv, input logic [14:0] da);
        in_valid = 1'b1; in_inst_id = id; in_raw_instr = $urandom; in_pc = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            src_valid[i] = sv[i]; src_arn[i] = sa[5*i +: 5];
            dst_valid[i] = dv[i]; dst_arn[i] = da[5*i +: 5];
        end
    endtask

    task automatic do_reset();
        idle();
        queue_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // One clock: predict at the falling edge, compare just after the rising edge.
    task automatic cycle();
        bit wk [64];
        bit exp_rdy, acc;
        int need, p;
        int allocs [$];
        out_t e, got;
        @(negedge clk);
        for (int q = 0; q < 64; q++) wk[q] = 1'b0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 3; i++)
                if (set_prn_ready[f][i]) wk[set_prn[f][i]] = 1'b1;
        need = 0;
        for (int i = 0; i < 3; i++) if (dst_valid[i] && dst_arn[i] != 5'd31) need++;
        exp_rdy = (!m_out_valid || queue_ready) && (m_free.size() >= need);
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready got=%b exp=%b", in_ready, exp_rdy);
        end
        acc = in_valid && exp_rdy;
        if (acc) begin
            e = '0;
            e.id = in_inst_id; e.raw = in_raw_instr; e.pc = in_pc;
            for (int i = 0; i < 3; i++) begin
                p = src_valid[i] ? m_map[src_arn[i]] : 0;
                e.piv[i] = src_valid[i];
                e.pi[i]  = 6'(p);
                e.pir[i] = src_valid[i] && (m_ready[p] || wk[p]);
            end
            for (int i = 0; i < 3; i++) begin
                e.pov[i] = dst_valid[i];
                if (dst_valid[i] && dst_arn[i] != 5'd31) begin
                    p = m_free.pop_front();
                    e.po[i] = 6'(p);
                    m_map[dst_arn[i]] = p;
                    allocs.push_back(p);
                    pool.push_back(p);
                end
            end
            sb.push_back(e);
            m_out = e;
            m_out_valid = 1'b1;
        end else if (queue_ready) begin
            m_out_valid = 1'b0;
        end else if (m_out_valid) begin
            for (int i = 0; i < 3; i++)
                if (m_out.piv[i] && wk[m_out.pi[i]]) m_out.pir[i] = 1'b1;
        end
        for (int q = 0; q < 64; q++) if (wk[q]) m_ready[q] = 1'b1;
        foreach (allocs[k]) m_ready[allocs[k]] = 1'b0;
        m_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++)
            if (free_valid[i] && free_prn[i] != 6'd0) m_free.push_back(free_prn[i]);
        @(posedge clk);
        #1;
        checks++;
        if (inst_valid !== m_out_valid) begin
            errors++;
            $display("FAIL inst_valid got=%b exp=%b", inst_valid, m_out_valid);
        end
        checks++;
        if (free_count !== 7'(m_free.size())) begin
            errors++;
            $display("FAIL free_count got=%0d exp=%0d", free_count, m_free.size());
        end
        got = dut_out();
        if (acc) begin
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL sb_out id=%0d got=%h exp=%h", e.id, got, e);
            end
        end else if (m_out_valid) begin
            checks++;
            if (got.pir !== m_out.pir || got.pi !== m_out.pi) begin
                errors++;
                $display("FAIL held_out got pir=%b pi=%h exp pir=%b pi=%h", got.pir, got.pi, m_out.pir, m_out.pi);
            end
        end
        last_acc = acc;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (inst_valid !== 1'b0 || free_count !== 7'd32 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got iv=%b fc=%0d rdy=%b exp iv=0 fc=32 rdy=1", inst_valid, free_count, in_ready);
        end
        $display("test_reset: free_count=%0d inst_valid=%b", free_count, inst_valid);
    endtask

    task automatic test_basic_rename();
        do_reset();
        set_inst(6'd1, 3'b011, {5'd0, 5'd2, 5'd1}, 3'b001, {5'd0, 5'd0, 5'd3});
        cycle();
        checks++;
        if (prn_output[0] !== 6'd32 || prn_input[0] !== 6'd2 || prn_input[1] !== 6'd3 ||
            prn_input_ready[0] !== 1'b1 || prn_input_ready[1] !== 1'b1 || free_count !== 7'd31) begin
            errors++;
            $display("FAIL basic_rename got po=%0d pi=%0d,%0d rdy=%b%b fc=%0d exp po=32 pi=2,3 rdy=11 fc=31",
                     prn_output[0], prn_input[0], prn_input[1], prn_input_ready[0], prn_input_ready[1], free_count);
        end
        idle();
        set_inst(6'd2, 3'b001, {5'd0, 5'd0, 5'd3}, 3'b000, '0);
        cycle();
        checks++;
        if (prn_input[0] !== 6'd32) begin
            errors++;
            $display("FAIL map3_updated got=%0d exp=32", prn_input[0]);
        end
        idle();
        cycle();
        $display("test_basic_rename: po0=32 pi={2,3} checked");
    endtask

    task automatic test_dependency_wakeup();
        do_reset();
        set_inst(6'd3, 3'b000, '0, 3'b001, {5'd0, 5'd0, 5'd3});
        cycle();
        set_inst(6'd4, 3'b001, {5'd0, 5'd0, 5'd3}, 3'b000, '0);
        cycle();
        checks++;
        if (prn_input[0] !== 6'd32 || prn_input_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL dep_src got pi=%0d rdy=%b exp pi=32 rdy=0", prn_input[0], prn_input_ready[0]);
        end
        idle();
        queue_ready = 1'b0;
        cycle();
        set_prn_ready[0][0] = 1'b1; set_prn[0][0] = 6'd32;
        cycle();
        checks++;
        if (inst_valid !== 1'b1 || prn_input_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL held_wakeup got iv=%b rdy=%b exp iv=1 rdy=1", inst_valid, prn_input_ready[0]);
        end
        idle();
        queue_ready = 1'b1;
        cycle();
        $display("test_dependency_wakeup: held wakeup checked");
    endtask

    task automatic test_src_dst_same();
        do_reset();
        set_inst(6'd5, 3'b001, {5'd0, 5'd0, 5'd5}, 3'b001, {5'd0, 5'd0, 5'd5});
        cycle();
        checks++;
        if (prn_input[0] !== 6'd6 || prn_output[0] !== 6'd32) begin
            errors++;
            $display("FAIL src_dst_same got pi=%0d po=%0d exp pi=6 po=32", prn_input[0], prn_output[0]);
        end
        idle();
        cycle();
        $display("test_src_dst_same: pi=%0d po=%0d", prn_input[0], prn_output[0]);
    endtask

    task automatic test_exhaust_free();
        do_reset();
        for (int n = 0; n < 10; n++) begin
            set_inst(6'(n), 3'b000, '0, 3'b111, {5'd3, 5'd2, 5'd1});
            cycle();
        end
        set_inst(6'd10, 3'b000, '0, 3'b011, {5'd0, 5'd5, 5'd4});
        cycle();
        set_inst(6'd11, 3'b000, '0, 3'b001, {5'd0, 5'd0, 5'd4});
        #1;
        checks++;
        if (free_count !== 7'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL exhaust got fc=%0d rdy=%b exp fc=0 rdy=0", free_count, in_ready);
        end
        free_valid[0] = 1'b1; free_prn[0] = 6'd7;
        cycle();
        free_valid[0] = 1'b0; free_prn[0] = '0;
        cycle();
        checks++;
        if (last_acc !== 1'b1 || prn_output[0] !== 6'd7 || free_count !== 7'd0) begin
            errors++;
            $display("FAIL refill got acc=%b po=%0d fc=%0d exp acc=1 po=7 fc=0", last_acc, prn_output[0], free_count);
        end
        idle();
        cycle();
        $display("test_exhaust_free: reuse po=%0d", prn_output[0]);
    endtask

    task automatic test_xzr();
        do_reset();
        set_inst(6'd12, 3'b001, {5'd0, 5'd0, 5'd31}, 3'b001, {5'd0, 5'd0, 5'd31});
        cycle();
        checks++;
        if (prn_output[0] !== 6'd0 || prn_output_valid[0] !== 1'b1 || prn_input[0] !== 6'd0 ||
            prn_input_ready[0] !== 1'b1 || free_count !== 7'd32) begin
            errors++;
            $display("FAIL xzr got po=%0d pov=%b pi=%0d rdy=%b fc=%0d exp 0 1 0 1 32",
                     prn_output[0], prn_output_valid[0], prn_input[0], prn_input_ready[0], free_count);
        end
        idle();
        free_valid[1] = 1'b1; free_prn[1] = 6'd0;
        cycle();
        idle();
        cycle();
        checks++;
        if (free_count !== 7'd32) begin
            errors++;
            $display("FAIL free_prn0 got fc=%0d exp=32", free_count);
        end
        $display("test_xzr: free_count=%0d", free_count);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            set_inst(6'(20 + n), 3'b001, {5'd0, 5'd0, 5'd9}, 3'b111, {5'd12, 5'd11, 5'd10});
            cycle();
        end
        idle();
        queue_ready = 1'b0;
        cycle();
        checks++;
        if (free_count !== 7'd20 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got fc=%0d iv=%b exp fc=20 iv=1", free_count, inst_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || free_count !== 7'd32) begin
            errors++;
            $display("FAIL async_reset got iv=%b fc=%0d exp iv=0 fc=32", inst_valid, free_count);
        end
        do_reset();
        set_inst(6'd30, 3'b111, {5'd30, 5'd10, 5'd0}, 3'b000, '0);
        cycle();
        checks++;
        if (prn_input[0] !== 6'd1 || prn_input[1] !== 6'd11 || prn_input[2] !== 6'd31) begin
            errors++;
            $display("FAIL map_restored got %0d,%0d,%0d exp 1,11,31", prn_input[0], prn_input[1], prn_input[2]);
        end
        idle();
        cycle();
        $display("test_reset_mid_stall: map restored");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            queue_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) begin
                set_inst(6'($urandom), 3'($urandom), 15'($urandom), 3'($urandom), 15'($urandom));
            end
            for (int i = 0; i < 3; i++) begin
                if (pool.size() > 0 && $urandom_range(0, 2) == 0) begin
                    free_valid[i] = 1'b1;
                    free_prn[i] = 6'(pool.pop_front());
                end
                if ($urandom_range(0, 3) == 0) begin
                    set_prn_ready[i][i] = 1'b1;
                    set_prn[i][i] = 6'($urandom_range(0, 63));
                end
            end
            cycle();
        end
        idle();
        queue_ready = 1'b1;
        cycle();
        $display("test_back_to_back: 400 random cycles, scoreboard left=%0d", sb.size());
    endtask

    initial begin
        idle();
        queue_ready = 1'b1;
        test_reset();
        test_basic_rename();
        test_dependency_wakeup();
        test_src_dst_same();
        test_exhaust_free();
        test_xzr();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
